alu_sliced: RTL and testbench

Parametrised, multi-cycle successor to the 128-bit combinational ALU. It processes a DWIDTH-bit operation in SLICE-bit chunks, LSB slice first, over DWIDTH/SLICE clock cycles. The chunks are joined by a registered carry chain. Flags persist between operations, so the block supports carry-chained instructions (add-with-carry, subtract-with-borrow). It sits in the datapath behind the operand registers and uses a start/busy/done handshake.

---
 rtl/alu_sliced_if.sv | 31 +++
 rtl/alu_sliced.sv | 173 +++++++++++++++++
 tb/tb_alu_sliced.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_sliced_if.sv
// Request/response bundle for the sliced ALU: operands and opcode in,
// start/ready/busy/done handshake, registered result and flags out.
interface alu_sliced_if #(
    parameter int DWIDTH = 128
);
    logic              start;
    logic              mode;
    logic [2:0]        opsel;
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DWIDTH-1:0] result;
    logic              c_flag;
    logic              z_flag;
    logic              o_flag;
    logic              s_flag;

    modport master (
        output start, mode, opsel, op1, op2,
        input  ready, busy, done, result,
        input  c_flag, z_flag, o_flag, s_flag
    );

    modport slave (
        input  start, mode, opsel, op1, op2,
        output ready, busy, done, result,
        output c_flag, z_flag, o_flag, s_flag
    );
endinterface

// File: rtl/alu_sliced.sv
// Multi-cycle ALU: DWIDTH-bit op computed SLICE bits per cycle, LSB first.
// Ports: clk, rst (sync, active-high), bus (alu_sliced_if.slave).
module alu_sliced #(
    parameter int DWIDTH = 128,
    parameter int SLICE  = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_sliced_if.slave  bus
);
    localparam int NSLICE = DWIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = DWIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [DWIDTH-1:0] a_q, a_d;
    logic [DWIDTH-1:0] b_q, b_d;
    logic [3:0]        opc_q, opc_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] res_q, res_d;
    logic              c_q, c_d, z_q, z_d, o_q, o_d, s_q, s_d;
    logic              busy_q, done_q;

    logic              ready;
    logic              accept;
    logic              last;
    logic [3:0]        opc_in;
    logic [DWIDTH-1:0] beff_in;
    logic              cin_in;
    logic [SLICE-1:0]  a_sl, b_sl;
    logic [SLICE:0]    sum_sl;
    logic              arith, sub_cls;
    logic [DWIDTH-1:0] fin;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = ready && bus.start;
    assign last   = (cnt_q == CW'(NSLICE - 1));
    assign opc_in = {bus.mode, bus.opsel};

    // Operand B and carry-in folded so every arithmetic op is A + Beff + cin.
    always_comb begin
        beff_in = bus.op2;
        cin_in  = 1'b0;
        unique case (opc_in)
            4'h1: begin beff_in = ~bus.op2; cin_in = ~c_q; end
            4'h3: begin beff_in = ~bus.op2; cin_in = 1'b1; end
            4'h4: begin beff_in = '0;       cin_in = 1'b1; end
            4'h5: begin beff_in = '1;       cin_in = 1'b0; end
            4'h6: cin_in = 1'b1;
            4'h7: cin_in = c_q;
            default: ;
        endcase
    end

    assign arith   = !opc_q[3] && (opc_q[2:0] != 3'd2);
    assign sub_cls = (opc_q == 4'h1) || (opc_q == 4'h3) || (opc_q == 4'h5);

    assign a_sl   = a_q[int'(cnt_q)*SLICE +: SLICE];
    assign b_sl   = b_q[int'(cnt_q)*SLICE +: SLICE];
    assign sum_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        opc_d   = opc_q;
        acc_d   = acc_q;
        res_d   = res_q;
        c_d     = c_q;
        z_d     = z_q;
        o_d     = o_q;
        s_d     = s_q;
        fin     = '0;

        if (accept) begin
            a_d     = bus.op1;
            b_d     = beff_in;
            opc_d   = opc_in;
            carry_d = cin_in;
        end

        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_BUSY;
            S_BUSY: begin
                acc_d[int'(cnt_q)*SLICE +: SLICE] = sum_sl[SLICE-1:0];
                carry_d = sum_sl[SLICE];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    unique case (opc_q)
                        4'h2:    fin = a_q;
                        4'h8:    fin = a_q & b_q;
                        4'h9:    fin = a_q | b_q;
                        4'hA:    fin = a_q ^ b_q;
                        4'hB:    fin = ~a_q;
                        4'hC:    fin = a_q >> 1;
                        4'hD:    fin = a_q << 1;
                        4'hE,
                        4'hF:    fin = '0;
                        default: fin = acc_d;
                    endcase
                    res_d = fin;
                    z_d   = (fin == '0);
                    s_d   = fin[MSB];
                    c_d   = 1'b0;
                    o_d   = 1'b0;
                    if (arith) begin
                        // Subtract class reports borrow, not carry.
                        c_d = sum_sl[SLICE] ^ sub_cls;
                        o_d = (a_q[MSB] == b_q[MSB]) && (fin[MSB] != a_q[MSB]);
                    end else if (opc_q == 4'hC) begin
                        c_d = a_q[0];
                    end else if (opc_q == 4'hD) begin
                        c_d = a_q[MSB];
                    end
                end
            end
            S_DONE: state_d = bus.start ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            o_q     <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            c_q     <= c_d;
            z_q     <= z_d;
            o_q     <= o_d;
            s_q     <= s_d;
            busy_q  <= (state_d == S_BUSY);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.ready  = ready;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.c_flag = c_q;
    assign bus.z_flag = z_q;
    assign bus.o_flag = o_q;
    assign bus.s_flag = s_q;
endmodule

// File: tb/tb_alu_sliced.sv
// Directed vector bench for alu_sliced at SLICE = 128, 32 and 8.
// The same vectors and corner sequences are run against each instance.
module tb_alu_sliced;
    localparam int W = 128;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c, z, o, s;
        bit           chain;
    } vec_t;

    localparam int NV = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] opc = '0;
    logic [W-1:0] a_in = '0, b_in = '0;
    int sel = 0;
    int npass = 0, ntot = 0;

    always #5 clk = ~clk;

    alu_sliced_if #(.DWIDTH(W)) b0 ();
    alu_sliced_if #(.DWIDTH(W)) b1 ();
    alu_sliced_if #(.DWIDTH(W)) b2 ();

    alu_sliced #(.DWIDTH(W), .SLICE(128)) u0 (.clk(clk), .rst(rst), .bus(b0));
    alu_sliced #(.DWIDTH(W), .SLICE(32))  u1 (.clk(clk), .rst(rst), .bus(b1));
    alu_sliced #(.DWIDTH(W), .SLICE(8))   u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.start = start && (sel == 0);
    assign b1.start = start && (sel == 1);
    assign b2.start = start && (sel == 2);
    assign b0.mode = opc[3]; assign b0.opsel = opc[2:0];
    assign b1.mode = opc[3]; assign b1.opsel = opc[2:0];
    assign b2.mode = opc[3]; assign b2.opsel = opc[2:0];
    assign b0.op1 = a_in; assign b0.op2 = b_in;
    assign b1.op1 = a_in; assign b1.op2 = b_in;
    assign b2.op1 = a_in; assign b2.op2 = b_in;

    logic ready_m, busy_m, done_m, c_m, z_m, o_m, s_m;
    logic [W-1:0] res_m;

    always_comb begin
        ready_m = b0.ready; busy_m = b0.busy; done_m = b0.done;
        res_m = b0.result;
        c_m = b0.c_flag; z_m = b0.z_flag; o_m = b0.o_flag; s_m = b0.s_flag;
        if (sel == 1) begin
            ready_m = b1.ready; busy_m = b1.busy; done_m = b1.done;
            res_m = b1.result;
            c_m = b1.c_flag; z_m = b1.z_flag; o_m = b1.o_flag; s_m = b1.s_flag;
        end else if (sel == 2) begin
            ready_m = b2.ready; busy_m = b2.busy; done_m = b2.done;
            res_m = b2.result;
            c_m = b2.c_flag; z_m = b2.z_flag; o_m = b2.o_flag; s_m = b2.s_flag;
        end
    end

    vec_t v [NV];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL sel=%0d %s: got %h expected %h", sel, name, act, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        opc = op; a_in = a; b_in = b; start = 1'b1;
    endtask

    task automatic run_op(input int i, input int ns);
        int lat, bcnt;
        bit got;
        lat = 0; bcnt = 0; got = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_low", W'(ready_m), W'(0));
        if (busy_m) bcnt++;
        repeat (40) begin
            @(posedge clk); #1;
            lat++;
            if (done_m) begin got = 1; break; end
            if (busy_m) bcnt++;
        end
        chk($sformatf("v%0d_done_seen", i), W'(got), W'(1));
        chk($sformatf("v%0d_latency", i), W'(lat), W'(ns));
        chk($sformatf("v%0d_busy_cycles", i), W'(bcnt), W'(ns));
        chk($sformatf("v%0d_result", i), res_m, v[i].r);
        chk($sformatf("v%0d_flags_czos", i), W'({c_m, z_m, o_m, s_m}),
            W'({v[i].c, v[i].z, v[i].o, v[i].s}));
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

    initial begin
        int ns;
        int dones;
        v[0]  = '{4'h0, 128'hFFFF_FFFF, 128'h1, 128'h1_0000_0000, 0, 0, 0, 0, 0};
        v[1]  = '{4'h0, ONES, 128'h1, 128'h0, 1, 1, 0, 0, 0};
        v[2]  = '{4'h1, 128'h5, 128'h2, 128'h2, 0, 0, 0, 0, 1};
        v[3]  = '{4'h7, 128'h3, 128'h4, 128'h7, 0, 0, 0, 0, 1};
        v[4]  = '{4'h3, 128'h0, 128'h1, ONES, 1, 0, 0, 1, 0};
        v[5]  = '{4'h0, MAXP, 128'h1, MINV, 0, 0, 1, 1, 0};
        v[6]  = '{4'hD, MINV | 128'h1, 128'h0, 128'h2, 1, 0, 0, 0, 0};
        v[7]  = '{4'hC, 128'h1, 128'h0, 128'h0, 1, 1, 0, 0, 0};
        v[8]  = '{4'hA, 128'hA5A5, 128'hA5A5, 128'h0, 0, 1, 0, 0, 0};
        v[9]  = '{4'hB, 128'h0, 128'h0, ONES, 0, 0, 0, 1, 0};
        v[10] = '{4'h4, ONES, 128'h0, 128'h0, 1, 1, 0, 0, 0};
        v[11] = '{4'h7, 128'h3, 128'h4, 128'h8, 0, 0, 0, 0, 1};
        v[12] = '{4'h5, 128'h0, 128'h55, ONES, 1, 0, 0, 1, 0};
        v[13] = '{4'h2, MINV, 128'h5, MINV, 0, 0, 0, 1, 0};
        v[14] = '{4'h6, 128'h1, 128'h2, 128'h4, 0, 0, 0, 0, 0};
        v[15] = '{4'h8, 128'hF0, 128'h3C, 128'h30, 0, 0, 0, 0, 0};
        v[16] = '{4'h9, 128'hF0, 128'h3C, 128'hFC, 0, 0, 0, 0, 0};
        v[17] = '{4'hE, 128'h5, 128'h5, 128'h0, 0, 1, 0, 0, 0};

        for (int s = 0; s < 3; s++) begin
            sel = s;
            ns = (s == 0) ? 1 : (s == 1) ? 4 : 16;
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("rst_busy", W'(busy_m), W'(0));
            chk("rst_done", W'(done_m), W'(0));
            chk("rst_ready", W'(ready_m), W'(1));
            chk("rst_result", res_m, W'(0));
            chk("rst_flags", W'({c_m, z_m, o_m, s_m}), W'(0));
            rst = 1'b0;

            for (int i = 0; i < NV; i++) begin
                issue(v[i].op, v[i].a, v[i].b);
                run_op(i, ns);
                if (i == NV - 1 || !v[i+1].chain) begin
                    @(posedge clk); #1;
                    chk($sformatf("v%0d_done_pulse", i), W'(done_m), W'(0));
                    chk($sformatf("v%0d_idle_ready", i), W'(ready_m), W'(1));
                end
            end

            // start held into the first BUSY-sampled edge must be ignored
            issue(4'h3, 128'h0, 128'h1);
            @(posedge clk); #1;
            dones = 0;
            @(posedge clk); #1;
            start = 1'b0;
            if (done_m) dones++;
            repeat (40) begin
                @(posedge clk); #1;
                if (done_m) dones++;
            end
            chk("ignore_start_dones", W'(dones), W'(1));
            chk("ignore_start_result", res_m, ONES);
            chk("ignore_start_flags", W'({c_m, z_m, o_m, s_m}), W'(4'b1001));

            // reset in the second BUSY cycle (the only one when ns == 1)
            issue(4'h0, 128'h10, 128'h20);
            @(posedge clk); #1;
            start = 1'b0;
            if (ns > 1) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            chk("midrst_busy", W'(busy_m), W'(0));
            chk("midrst_ready", W'(ready_m), W'(1));
            chk("midrst_done", W'(done_m), W'(0));
            chk("midrst_result", res_m, W'(0));
            chk("midrst_flags", W'({c_m, z_m, o_m, s_m}), W'(0));
            rst = 1'b0;
            dones = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done_m) dones++;
            end
            chk("midrst_no_done", W'(dones), W'(0));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
